// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-path bridge: trigger FSM encoding,
// default sizing and the pointer-width helper used by the FIFO and its interface.
package sdram_pkg;

    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_BURST_LEN = 4;
    localparam int DEFAULT_TIMEOUT   = 1023;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_TRIG = 3'b010,
        ST_WAIT = 3'b100
    } trig_state_e;

    // One extra bit over the address so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rfifo_tx_bridge_if.sv
// Bundle of the bridge's control, SDRAM read-path and UART TX stream signals.
// The slave modport is the bridge side; the master modport is the environment side.
interface rfifo_tx_bridge_if
    import sdram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);
    logic                          rd_enable;
    logic                          clr_status;
    logic                          rfifo_wr_en;
    logic [7:0]                    rfifo_wr_data;
    logic                          rd_trig;
    logic [7:0]                    tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic [ptr_width(DEPTH)-1:0]   fifo_level;
    logic                          overflow;
    logic                          timeout;

    modport slave (
        input  rd_enable, clr_status, rfifo_wr_en, rfifo_wr_data, tx_ready,
        output rd_trig, tx_data, tx_valid, fifo_level, overflow, timeout
    );

    modport master (
        output rd_enable, clr_status, rfifo_wr_en, rfifo_wr_data, tx_ready,
        input  rd_trig, tx_data, tx_valid, fifo_level, overflow, timeout
    );
endinterface

// File: rtl/byte_sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO. The head byte, valid flag and
// occupancy are registered so they come straight from flops.
module byte_sync_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        sclk,
    input  logic                        s_rst_n,
    input  logic                        wr_en_i,
    input  logic [7:0]                  wr_data_i,
    input  logic                        rd_en_i,
    output logic [7:0]                  rd_data_o,
    output logic                        rd_valid_o,
    output logic [ptr_width(DEPTH)-1:0] level_o,
    output logic                        drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic [7:0]    head_q, head_d;
    logic          valid_q, valid_d;
    logic          full_s, empty_s, push_s, pop_s;

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign push_s  = wr_en_i & ~full_s;
    assign pop_s   = rd_en_i & ~empty_s;
    assign drop_o  = wr_en_i & full_s;

    // Next pointers, occupancy and the head byte as seen after this edge.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        level_d  = wr_ptr_d - rd_ptr_d;
        valid_d  = (level_d != {PW{1'b0}});
        // The new head is the byte being written only when the FIFO drains to it this cycle.
        if (!valid_d) begin
            head_d = 8'h00;
        end else if (push_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_d = wr_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Byte storage; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge sclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Pointer, occupancy and output registers.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {PW{1'b0}};
            head_q   <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_data_o  = head_q;
    assign rd_valid_o = valid_q;
    assign level_o    = level_q;

endmodule

// File: rtl/rfifo_tx_bridge.sv
// Bridges SDRAM read bursts into a byte stream for a UART transmitter: issues one
// read trigger at a time while the FIFO has room for a whole burst, with a watchdog.
module rfifo_tx_bridge
    import sdram_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    rfifo_tx_bridge_if.slave bus
);
    localparam int PW = ptr_width(DEPTH);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] MAX_TRIG_LEVEL = PW'(DEPTH - BURST_LEN);
    localparam logic [BW-1:0] BURST_LAST     = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BCNT_ONE       = BW'(1);
    localparam logic [TW-1:0] TIMEOUT_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_ONE       = TW'(1);

    trig_state_e   state_q;
    logic          rd_trig_q;
    logic [BW-1:0] bcnt_q;
    logic [TW-1:0] tcnt_q;
    logic          overflow_q;
    logic          timeout_q;

    logic [PW-1:0] level_s;
    logic [7:0]    tx_data_s;
    logic          tx_valid_s;
    logic          drop_s;
    logic          room_ok_s;
    logic          burst_done_s;
    logic          tmo_hit_s;

    byte_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .wr_en_i    (bus.rfifo_wr_en),
        .wr_data_i  (bus.rfifo_wr_data),
        .rd_en_i    (bus.tx_ready),
        .rd_data_o  (tx_data_s),
        .rd_valid_o (tx_valid_s),
        .level_o    (level_s),
        .drop_o     (drop_s)
    );

    assign room_ok_s    = (level_s <= MAX_TRIG_LEVEL);
    assign burst_done_s = (state_q == ST_WAIT) && bus.rfifo_wr_en && (bcnt_q == BURST_LAST);
    assign tmo_hit_s    = (state_q == ST_WAIT) && (tcnt_q == TIMEOUT_LAST);

    // Trigger FSM with burst/watchdog counters; completion beats the watchdog on a tie.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            rd_trig_q <= 1'b0;
            bcnt_q    <= {BW{1'b0}};
            tcnt_q    <= {TW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rd_enable && room_ok_s) begin
                        state_q   <= ST_TRIG;
                        rd_trig_q <= 1'b1;
                    end else begin
                        rd_trig_q <= 1'b0;
                    end
                end
                ST_TRIG: begin
                    state_q   <= ST_WAIT;
                    rd_trig_q <= 1'b0;
                    bcnt_q    <= {BW{1'b0}};
                    tcnt_q    <= {TW{1'b0}};
                end
                ST_WAIT: begin
                    rd_trig_q <= 1'b0;
                    tcnt_q    <= tcnt_q + TCNT_ONE;
                    if (bus.rfifo_wr_en) begin
                        bcnt_q <= bcnt_q + BCNT_ONE;
                    end
                    if (burst_done_s || tmo_hit_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rd_trig_q <= 1'b0;
                end
            endcase

            if (tmo_hit_s && !burst_done_s) begin
                timeout_q <= 1'b1;
            end else if (bus.clr_status) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop_s) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_status) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.rd_trig    = rd_trig_q;
    assign bus.tx_data    = tx_data_s;
    assign bus.tx_valid   = tx_valid_s;
    assign bus.fifo_level = level_s;
    assign bus.overflow   = overflow_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: doc/rfifo_tx_bridge.md
RFIFO_TX_BRIDGE -- requirements
Module: rfifo_tx_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 16, byte FIFO depth (power of two, >= 2*BURST_LEN).
REQ-002 SHALL have parameter BURST_LEN, default 4, bytes returned by the SDRAM read path per rd_trig.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max sclk cycles waiting for a burst to complete.
REQ-004 sclk  input  1  system clock, 100 MHz; reset s_rst_n, asynchronous, active-low; clock sclk.
REQ-005 s_rst_n  input  1  asynchronous active-low reset.
REQ-006 rd_enable  input  1  level; permits issuing new read triggers.
REQ-007 clr_status  input  1  one-cycle pulse; clears sticky flags.
REQ-008 rfifo_wr_en  input  1  byte strobe from SDRAM read path.
REQ-009 rfifo_wr_data  input  8  byte from SDRAM read path.
REQ-010 rd_trig  output  1  one-cycle pulse requesting one SDRAM read burst.
REQ-011 tx_data  output  8  head-of-FIFO byte to downstream consumer (UART TX).
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  consumer accepts tx_data.
REQ-014 fifo_level  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky; byte dropped because FIFO full.
REQ-016 timeout  output  1  sticky; burst did not complete within TIMEOUT cycles.

Function
REQ-017 Push SHALL occur when rfifo_wr_en=1 and level<DEPTH; rfifo_wr_en=1 at level==DEPTH SHALL drop the byte and set overflow, even if a pop occurs that cycle.
REQ-018 Pop SHALL occur when tx_valid=1 and tx_ready=1; tx_valid SHALL equal (level!=0).
REQ-019 FIFO SHALL be first-word-fall-through: byte pushed into empty FIFO at edge N appears on tx_data/tx_valid after edge N (cycle N+1).
REQ-020 Pointers SHALL be $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and lower bits equal; empty = pointers equal.
REQ-021 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged; at level 0, push SHALL proceed and no pop occurs.
REQ-022 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-023 Trigger FSM states: IDLE, TRIG, WAIT (one-hot).
REQ-024 IDLE->TRIG when rd_enable=1 and (DEPTH-level)>=BURST_LEN; else stay.
REQ-025 TRIG: rd_trig=1 for exactly this one cycle; unconditionally ->WAIT; burst byte counter and timeout counter cleared.
REQ-026 WAIT: counter increments per rfifo_wr_en (including dropped bytes); ->IDLE on cycle where count reaches BURST_LEN.
REQ-027 WAIT: timeout counter increments each cycle; on reaching TIMEOUT ->IDLE and set timeout, unless the final burst byte arrives that same cycle (completion wins, timeout not set).
REQ-028 rd_enable deassertion SHALL NOT abort TRIG or WAIT; it only blocks the IDLE->TRIG transition.
REQ-029 At most one burst SHALL be outstanding; rd_trig SHALL never be asserted in consecutive cycles.
REQ-030 rfifo_wr_en in IDLE SHALL still be pushed (stray bytes accepted), not counted.
REQ-031 clr_status SHALL clear overflow and timeout; a set event in the same cycle SHALL win.

Reset
REQ-032 On s_rst_n=0: state=IDLE, pointers=0, level=0, rd_trig=0, tx_valid=0, tx_data=0, overflow=0, timeout=0, counters=0.
REQ-033 Reset mid-burst SHALL discard FIFO contents and outstanding-burst state; first rd_trig after release no earlier than cycle 2.

Structure
REQ-034 FSM state encodings and default DEPTH/BURST_LEN/TIMEOUT SHALL live in shared package sdram_pkg.
REQ-035 FIFO storage/pointers SHALL be sub-module byte_sync_fifo; trigger FSM, counters, flags in top level.

Verification
REQ-036 Reset, rd_enable=1, tx_ready=1, 4 bytes 0xA1..0xA4 returned 3 cycles after each rd_trig -> repeated rd_trig pulses, tx_data sequence A1,A2,A3,A4 in order, overflow=0.
REQ-037 tx_ready=0, rd_enable=1, bursts answered -> exactly 4 rd_trig pulses, fifo_level=16, no 5th rd_trig, tx_valid=1.
REQ-038 FIFO full (level=16), rfifo_wr_en=1 with tx_ready=1 same cycle -> byte dropped, overflow=1, level=15.
REQ-039 rd_trig unanswered -> timeout=1 after 1023 WAIT cycles, FSM back to IDLE, new rd_trig next cycle.
REQ-040 Assert s_rst_n=0 after 2 of 4 burst bytes -> level=0, tx_valid=0, rd_trig=0; fresh burst completes normally after release.
REQ-041 clr_status coincident with overflow event -> overflow stays 1; clr_status alone -> overflow=0, timeout=0 next cycle.
